// File: rtl/tff_bank_ctrl_if.sv
// Command handshake and T-flop bank connection for tff_bank_ctrl.
// The slave modport is the controller view; master is the command source / bank view.
interface tff_bank_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [1:0]       cmd_mode;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] toggle;
    logic             running;
    logic             done;
    logic             wrap;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_mode, q,
        output cmd_ready, toggle, running, done, wrap
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_mode, q,
        input  cmd_ready, toggle, running, done, wrap
    );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Sequences an external T-flop bank as a loadable, limit-wrapping counter using toggles only.
// Optional down counting is enabled by defining TFF_CTRL_DOWN_EN.
module tff_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    tff_bank_ctrl_if.slave ctl
);
    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_RUN, S_DONE} state_e;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             oneshot_q, oneshot_d;
    logic [WIDTH-1:0] toggle_c;
    logic             wrap_c;
    logic             accept;
    logic [WIDTH-1:0] inc_tog;

    // Bit i of an increment flips when every lower bit is one.
    assign inc_tog[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_inc
            assign inc_tog[gi] = &ctl.q[gi-1:0];
        end
    endgenerate

`ifdef TFF_CTRL_DOWN_EN
    logic             down_q, down_d;
    logic [WIDTH-1:0] dec_tog;

    assign dec_tog[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_dec
            assign dec_tog[gi] = ~|ctl.q[gi-1:0];
        end
    endgenerate
`else
    logic unused_mode_bit;
    assign unused_mode_bit = ctl.cmd_mode[1];
`endif

    assign accept = ctl.cmd_valid && (state_q != S_APPLY);

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        limit_d   = limit_q;
        oneshot_d = oneshot_q;
`ifdef TFF_CTRL_DOWN_EN
        down_d    = down_q;
`endif
        toggle_c  = '0;
        wrap_c    = 1'b0;

        if (state_q == S_APPLY) begin
            toggle_c = ctl.q ^ target_q;
            state_d  = S_IDLE;
        end else if (accept) begin
            // Commands pre-empt counting, so no wrap can occur in an accept cycle.
            case (ctl.cmd_op)
                OP_LOAD: begin
                    target_d = ctl.cmd_data;
                    state_d  = S_APPLY;
                end
                OP_START: begin
                    limit_d   = ctl.cmd_data;
                    oneshot_d = ctl.cmd_mode[0];
`ifdef TFF_CTRL_DOWN_EN
                    down_d    = ctl.cmd_mode[1];
`endif
                    state_d   = S_RUN;
                end
                OP_STOP: begin
                    state_d = S_IDLE;
                end
                default: begin
                    toggle_c = ctl.q;
                    state_d  = S_IDLE;
                end
            endcase
        end else if (state_q == S_RUN) begin
`ifdef TFF_CTRL_DOWN_EN
            if (down_q) begin
                if (ctl.q == '0) begin
                    toggle_c = ctl.q ^ limit_q;
                    wrap_c   = 1'b1;
                    state_d  = oneshot_q ? S_DONE : S_RUN;
                end else begin
                    toggle_c = dec_tog;
                end
            end else
`endif
            if (ctl.q == limit_q) begin
                toggle_c = ctl.q;
                wrap_c   = 1'b1;
                state_d  = oneshot_q ? S_DONE : S_RUN;
            end else begin
                toggle_c = inc_tog;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            limit_q   <= '0;
            oneshot_q <= 1'b0;
`ifdef TFF_CTRL_DOWN_EN
            down_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            limit_q   <= limit_d;
            oneshot_q <= oneshot_d;
`ifdef TFF_CTRL_DOWN_EN
            down_q    <= down_d;
`endif
        end
    end

    assign ctl.toggle    = toggle_c;
    assign ctl.wrap      = wrap_c;
    assign ctl.cmd_ready = (state_q != S_APPLY);
    assign ctl.running   = (state_q == S_RUN);
    assign ctl.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Scoreboarded random/directed bench for tff_bank_ctrl driving a behavioural T-flop bank.
module tb_tff_bank_ctrl;
    localparam int W = 4;
`ifdef TFF_CTRL_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_APPLY = 1, P_RUN = 2, P_DONE = 3;
    localparam logic [1:0] LOAD = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] tog;
        logic         rdy;
        logic         run;
        logic         dn;
        logic         wr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic bank_rst_n;
    logic [W-1:0] bank_q;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    int m_phase, m_q, m_target, m_limit;
    bit m_oneshot, m_down;

    tff_bank_ctrl_if #(.WIDTH(W)) bus ();

    tff_bank_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ctl    (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!bank_rst_n) bank_q <= '0;
        else             bank_q <= bank_q ^ bus.toggle;
    end
    assign bus.q = bank_q;

    function automatic void chk(string name, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endfunction

    // Monitor: one expected record per presented cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q",         int'(bus.q),        int'(e.q));
                chk("toggle",    int'(bus.toggle),   int'(e.tog));
                chk("cmd_ready", int'(bus.cmd_ready), int'(e.rdy));
                chk("running",   int'(bus.running),  int'(e.run));
                chk("done",      int'(bus.done),     int'(e.dn));
                chk("wrap",      int'(bus.wrap),     int'(e.wr));
            end
        end
    end

    task automatic model_reset();
        m_phase = P_IDLE; m_target = 0; m_limit = 0; m_oneshot = 0; m_down = 0;
    endtask

    // One clock cycle of stimulus; the reference model predicts this cycle's outputs.
    task automatic cycle(input logic v, input logic [1:0] op, input int data, input int mode);
        exp_t e;
        int nq, np;
        bit acc;
        @(posedge clk); #1;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_data  = W'(data);
        bus.cmd_mode  = 2'(mode);
        e.q   = W'(m_q);
        e.rdy = (m_phase != P_APPLY);
        e.run = (m_phase == P_RUN);
        e.dn  = (m_phase == P_DONE);
        e.wr  = 1'b0;
        acc = v && e.rdy;
        nq = m_q; np = m_phase;
        if (m_phase == P_APPLY) begin
            nq = m_target; np = P_IDLE;
        end else if (acc) begin
            case (op)
                LOAD:  begin m_target = data; np = P_APPLY; end
                START: begin
                    m_limit = data; m_oneshot = mode[0];
                    m_down = DOWN_EN && mode[1]; np = P_RUN;
                end
                STOP:  np = P_IDLE;
                default: begin nq = 0; np = P_IDLE; end
            endcase
        end else if (m_phase == P_RUN) begin
            if (m_down) begin
                if (m_q == 0) begin
                    nq = m_limit; e.wr = 1'b1; np = m_oneshot ? P_DONE : P_RUN;
                end else nq = m_q - 1;
            end else if (m_q == m_limit) begin
                nq = 0; e.wr = 1'b1; np = m_oneshot ? P_DONE : P_RUN;
            end else nq = (m_q + 1) % (1 << W);
        end
        e.tog = W'(m_q ^ nq);
        sb.push_back(e);
        m_q = nq; m_phase = np;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, LOAD, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0; bank_rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = LOAD; bus.cmd_data = '0; bus.cmd_mode = '0;
        model_reset(); m_q = 0;
        #1;
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_running",   int'(bus.running), 0);
        chk("rst_done",      int'(bus.done), 0);
        chk("rst_wrap",      int'(bus.wrap), 0);
        chk("rst_toggle",    int'(bus.toggle), 0);
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1; bank_rst_n = 1'b1;

        cycle(1, LOAD, 4'hA, 0); idle(3);
        cycle(1, CLEAR, 0, 0);
        cycle(1, START, 5, 0); idle(14);
        cycle(1, STOP, 0, 0); cycle(1, CLEAR, 0, 0);
        cycle(1, START, 3, 1); idle(8);
        cycle(1, LOAD, 7, 0); idle(1);
        cycle(1, START, 15, 0); cycle(1, STOP, 0, 0); idle(2);
        cycle(1, CLEAR, 0, 0); idle(1);
        cycle(1, START, 0, 0); idle(4);
        cycle(1, LOAD, 4'hC, 0); idle(1);
        cycle(1, START, 2, 0); idle(10);
        cycle(1, LOAD, 3, 0); idle(1);
        cycle(1, START, 9, 2); idle(15);
        cycle(1, START, 5, 3); idle(8);

        // Asynchronous reset in the middle of a free run.
        cycle(1, START, 15, 0); idle(3);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_running",   int'(bus.running), 0);
        chk("async_rst_toggle",    int'(bus.toggle), 0);
        chk("async_rst_wrap",      int'(bus.wrap), 0);
        chk("async_rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("async_rst_done",      int'(bus.done), 0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 500; i++) begin
            int r;
            logic [1:0] op;
            r = $urandom_range(0, 9);
            op = (r < 4 || r > 7) ? START : (r < 6) ? LOAD : (r == 6) ? STOP : CLEAR;
            cycle(($urandom_range(0, 3) == 0), op, $urandom_range(0, 15), $urandom_range(0, 3));
        end

        @(posedge clk); @(negedge clk); #1;
        if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
